// File: rtl/seg7_pkg.sv
// seg7_pkg: mode encodings and active-low glyph table for the seven-segment scanner
package seg7_pkg;
  typedef enum logic [1:0] {
    MODE_HEX     = 2'b00,
    MODE_HEX_LZB = 2'b01,
    MODE_OFF     = 2'b10,
    MODE_LAMP    = 2'b11
  } mode_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPHS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low glyph, bit0=CA .. bit6=CG
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);
  assign glyph = GLYPHS[nibble];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed common-anode display scanner with LZ blanking, blink, off and lamp test
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic                  load_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blink_i,
  input  logic [1:0]            mode_i,
  input  logic [15:0]           sw_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [DIGITS-1:0]     an_o,
  output logic [15:0]           LED
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [CW-1:0]            pre;
  logic [IW-1:0]            idx, nidx;
  logic [FW-1:0]            frm, nfrm;
  logic                     phase, nphase, tick, wrap, blank, any_nz;
  logic [DIGITS-1:0][3:0]   data_q;
  logic [DIGITS-1:0]        dp_q, blink_q;
  logic [6:0]               glyph;
  mode_t                    mode;
  assign mode   = mode_t'(mode_i);
  assign tick   = pre == CW'(REFRESH_DIV - 1);
  assign wrap   = idx == IW'(DIGITS - 1);
  assign nidx   = wrap ? '0 : idx + 1'b1;
  assign nfrm   = frm == FW'(BLINK_FRAMES - 1) ? '0 : frm + 1'b1;
  assign nphase = (tick && wrap && frm == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;
  seg7_hex_decode u_dec (.nibble(data_q[nidx]), .glyph(glyph));
  // LZ blanking: digit is dark when it and every more-significant nibble are zero
  always_comb begin
    any_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++)
      if (j >= int'(nidx) && data_q[j] != 4'h0) any_nz = 1'b1;
  end
  assign blank = mode == MODE_OFF || (blink_q[nidx] && nphase) ||
                 (mode == MODE_HEX_LZB && nidx != '0 && !any_nz);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre     <= '0;
      idx     <= '0;
      frm     <= '0;
      phase   <= 1'b0;
      data_q  <= '0;
      dp_q    <= '0;
      blink_q <= '0;
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      LED     <= '0;
    end else begin
      LED <= sw_i;
      if (load_i) begin
        data_q  <= data_i;
        dp_q    <= dp_i;
        blink_q <= blink_i;
      end
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        idx   <= nidx;
        phase <= nphase;
        if (wrap) frm <= nfrm;
        an_o  <= blank ? '1 : ~(DIGITS'(1) << nidx);
        seg_o <= blank ? SEG_BLANK : (mode == MODE_LAMP ? 7'h00 : glyph);
        dp_o  <= blank | (mode != MODE_LAMP & ~dp_q[nidx]);
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan timing, decode, blanking, blink, lamp test and reset
module tb_seg7_scan_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        load_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  blink_i = '0;
  logic [1:0]  mode_i = 2'b00;
  logic [15:0] sw_i = '0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic [15:0] LED;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg7_scan_ctrl #(.DIGITS(4), .REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .load_i(load_i), .dp_i(dp_i),
    .blink_i(blink_i), .mode_i(mode_i), .sw_i(sw_i), .seg_o(seg_o), .dp_o(dp_o),
    .an_o(an_o), .LED(LED)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg, input logic dp);
    chk({tag, ".an"}, 32'(an_o), 32'(an));
    chk({tag, ".seg"}, 32'(seg_o), 32'(seg));
    chk({tag, ".dp"}, 32'(dp_o), 32'(dp));
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk_i);
    @(negedge clk_i);
    cyc += n;
  endtask

  task automatic to_cyc(input int e);
    adv(e - cyc);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc = 0;
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_i = d; dp_i = dp; blink_i = bl; load_i = 1'b1;
    adv(1);
    load_i = 1'b0;
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();
    slot("rst", 4'hF, 7'h7F, 1'b1);
    chk("rst.led", 32'(LED), 32'h0);
    mode_i = 2'b00;
    load(16'h1234, 4'h0, 4'h0);
    to_cyc(3);
    slot("pre_tick", 4'hF, 7'h7F, 1'b1);
    to_cyc(4);  slot("hex.d1", 4'b1101, 7'h30, 1'b1);
    to_cyc(7);  slot("hex.d1hold", 4'b1101, 7'h30, 1'b1);
    to_cyc(8);  slot("hex.d2", 4'b1011, 7'h24, 1'b1);
    to_cyc(12); slot("hex.d3", 4'b0111, 7'h79, 1'b1);
    to_cyc(16); slot("hex.d0", 4'b1110, 7'h19, 1'b1);
    mode_i = 2'b01;
    load(16'h0050, 4'h0, 4'h0);
    to_cyc(20); slot("lzb.d1", 4'b1101, 7'h12, 1'b1);
    to_cyc(24); slot("lzb.d2", 4'hF, 7'h7F, 1'b1);
    to_cyc(28); slot("lzb.d3", 4'hF, 7'h7F, 1'b1);
    to_cyc(32); slot("lzb.d0", 4'b1110, 7'h40, 1'b1);
    load(16'h0000, 4'h0, 4'h0);
    to_cyc(36); slot("lz0.d1", 4'hF, 7'h7F, 1'b1);
    to_cyc(40); slot("lz0.d2", 4'hF, 7'h7F, 1'b1);
    to_cyc(44); slot("lz0.d3", 4'hF, 7'h7F, 1'b1);
    to_cyc(48); slot("lz0.d0", 4'b1110, 7'h40, 1'b1);

    do_reset();
    mode_i = 2'b00;
    load(16'h1234, 4'b0010, 4'b0001);
    to_cyc(16);  slot("blk.f1", 4'b1110, 7'h19, 1'b1);
    to_cyc(32);  slot("blk.f2", 4'hF, 7'h7F, 1'b1);
    to_cyc(36);  slot("blk.d1dp", 4'b1101, 7'h30, 1'b0);
    to_cyc(48);  slot("blk.f3", 4'hF, 7'h7F, 1'b1);
    to_cyc(64);  slot("blk.f4", 4'b1110, 7'h19, 1'b1);
    to_cyc(80);  slot("blk.f5", 4'b1110, 7'h19, 1'b1);
    to_cyc(96);  slot("blk.f6", 4'hF, 7'h7F, 1'b1);
    to_cyc(100); slot("blk.f6d1", 4'b1101, 7'h30, 1'b0);
    to_cyc(112); slot("blk.f7", 4'hF, 7'h7F, 1'b1);
    mode_i = 2'b11;
    load(16'h0000, 4'h0, 4'h0);
    to_cyc(116); slot("lamp.d1", 4'b1101, 7'h00, 1'b0);
    to_cyc(120); slot("lamp.d2", 4'b1011, 7'h00, 1'b0);
    to_cyc(121);
    mode_i = 2'b10;
    to_cyc(123); slot("off.midslot", 4'b1011, 7'h00, 1'b0);
    to_cyc(124); slot("off.d3", 4'hF, 7'h7F, 1'b1);
    sw_i = 16'hA5C3;
    chk("led.before", 32'(LED), 32'h0);
    adv(1);
    chk("led.after", 32'(LED), 32'hA5C3);

    do_reset();
    chk("rst2.led", 32'(LED), 32'h0);
    mode_i = 2'b00;
    load(16'h1234, 4'h0, 4'h0);
    to_cyc(7);
    data_i = 16'hFFFF; load_i = 1'b1;
    to_cyc(8);
    load_i = 1'b0;
    slot("ldtick.old", 4'b1011, 7'h24, 1'b1);
    to_cyc(12); slot("ldtick.new", 4'b0111, 7'h0E, 1'b1);
    to_cyc(14);
    rst_i = 1'b1;
    adv(1);
    slot("midrst", 4'hF, 7'h7F, 1'b1);
    chk("midrst.led", 32'(LED), 32'h0);
    rst_i = 1'b0;
    cyc = 0;
    to_cyc(3);  slot("postrst.pre", 4'hF, 7'h7F, 1'b1);
    chk("postrst.led", 32'(LED), 32'hA5C3);
    to_cyc(4);  slot("postrst.d1", 4'b1101, 7'h40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
